module_keypad_capture: RTL

- Scans a 4x4 matrix keypad, debounces and decodes presses, and assembles a two-digit decimal entry.
- On confirm, it drives the tens/units load strobes, the 4-bit digit bus and the ready strobe into the units/tens shift-load register directly downstream.
- Sits between the keypad pins and that register.

---
 rtl/module_keypad_capture_pkg.sv | 39 +++
 rtl/module_keypad_capture_if.sv | 32 +++
 rtl/module_keypad_capture_scan.sv | 104 ++++++++++
 rtl/module_keypad_capture.sv | 118 +++++++++++
 4 files changed

// File: rtl/module_keypad_capture_pkg.sv
// keypad_pkg: shared constants and types for the keypad capture slice.
//   KEY_STAR / KEY_HASH : codes of the clear and confirm keys
//   KEY_MAP             : (row, col) -> key code for the 4x4 matrix
//   scan_state_t        : scanner FSM states
//   entry_state_t       : two-digit entry FSM states
//   row_onehot()        : active-low one-hot row drive pattern
//   first_low()         : index of the lowest-numbered low column
package keypad_pkg;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  localparam logic [3:0] KEY_MAP [0:3][0:3] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  typedef enum logic [1:0] {SCAN, DEB_PRESS, WAIT_REL, DEB_REL} scan_state_t;

  typedef enum logic [2:0] {EMPTY, ONE, TWO, EMIT_D, EMIT_U, EMIT_RDY} entry_state_t;

  function automatic logic [3:0] row_onehot(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  function automatic logic [1:0] first_low(input logic [3:0] cols);
    logic [1:0] idx;
    casez (cols)
      4'b???0: idx = 2'd0;
      4'b??01: idx = 2'd1;
      4'b?011: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/module_keypad_capture_if.sv
// module_keypad_capture_if: bus from the keypad capture block to the
// units/tens shift-load register.
//   tecla_d     : digit value accompanying load_d / load_u
//   load_d      : one-cycle strobe, tecla_d is the tens digit
//   load_u      : one-cycle strobe, tecla_d is the units digit
//   rdy         : one-cycle strobe, both digits delivered
//   n_digits    : digits currently held (0..2)
//   scan_state  : scanner FSM state (debug)
//   entry_state : entry FSM state (debug)
// Handshake: push-only strobes with no back-pressure. The sink must accept
// a strobe in the cycle it is high; load_d, load_u and rdy are mutually
// exclusive and arrive as three consecutive single-cycle pulses.
interface module_keypad_capture_if;
  import keypad_pkg::*;

  logic [3:0]   tecla_d;
  logic         load_d;
  logic         load_u;
  logic         rdy;
  logic [1:0]   n_digits;
  scan_state_t  scan_state;
  entry_state_t entry_state;

  modport master (
    output tecla_d, load_d, load_u, rdy, n_digits, scan_state, entry_state
  );

  modport slave (
    input tecla_d, load_d, load_u, rdy, n_digits, scan_state, entry_state
  );

endinterface

// File: rtl/module_keypad_capture_scan.sv
// module_keypad_scan: keypad row scanner, debouncer and decoder.
//   clk, rst  : clock, synchronous active-low reset
//   col_in    : raw keypad columns (active-low, asynchronous)
//   row_out   : row drive, one-hot active-low
//   key_evt   : one-cycle pulse per debounced press
//   key_code  : code of the pressed key, valid with key_evt
//   state     : scanner FSM state (debug)
module module_keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 27_000,
  parameter int DEBOUNCE = 270_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  col_in,
  output logic [3:0]  row_out,
  output logic        key_evt,
  output logic [3:0]  key_code,
  output scan_state_t state
);

  localparam int CMAX = (SCAN_DIV > DEBOUNCE) ? SCAN_DIV : DEBOUNCE;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] CNT_SAT   = CW'(CMAX);

  logic [3:0]    col_s1, col_s2;
  logic [3:0]    col_pat;   // pattern captured when a press was first seen
  logic [1:0]    row_idx;
  logic [CW-1:0] cnt, cnt_inc;

  // Counter never wraps; the state logic always exits before saturation.
  assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + CW'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      col_s1   <= 4'hF;
      col_s2   <= 4'hF;
      col_pat  <= 4'hF;
      row_idx  <= 2'd0;
      row_out  <= 4'b1110;
      cnt      <= '0;
      state    <= SCAN;
      key_evt  <= 1'b0;
      key_code <= 4'h0;
    end else begin
      col_s1  <= col_in;
      col_s2  <= col_s1;
      key_evt <= 1'b0;
      case (state)
        SCAN: begin
          if (cnt == SCAN_LAST) begin
            cnt <= '0;
            if (col_s2 != 4'hF) begin
              col_pat <= col_s2;
              state   <= DEB_PRESS;
            end else begin
              row_idx <= row_idx + 2'd1;
              row_out <= row_onehot(row_idx + 2'd1);
            end
          end else begin
            cnt <= cnt_inc;
          end
        end
        DEB_PRESS: begin
          if (col_s2 != col_pat) begin
            // Bounce: resume scanning from the next row.
            cnt     <= '0;
            state   <= SCAN;
            row_idx <= row_idx + 2'd1;
            row_out <= row_onehot(row_idx + 2'd1);
          end else if (cnt == DEB_LAST) begin
            cnt      <= '0;
            key_evt  <= 1'b1;
            key_code <= KEY_MAP[row_idx][first_low(col_pat)];
            state    <= WAIT_REL;
          end else begin
            cnt <= cnt_inc;
          end
        end
        WAIT_REL: begin
          if (col_s2 == 4'hF) begin
            cnt   <= '0;
            state <= DEB_REL;
          end
        end
        DEB_REL: begin
          if (col_s2 != 4'hF) begin
            state <= WAIT_REL;
          end else if (cnt == DEB_LAST) begin
            cnt   <= '0;
            state <= SCAN;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: rtl/module_keypad_capture.sv
// module_keypad_capture: keypad scan + two-digit decimal entry. On '#'
// delivers tens then units then a ready strobe to the downstream register.
//   clk, rst : clock, synchronous active-low reset
//   col_in   : keypad columns (active-low, pulled up, asynchronous)
//   row_out  : keypad rows, one-hot active-low
//   out_if   : master side of module_keypad_capture_if (tecla_d, load_d,
//              load_u, rdy, n_digits, debug states)
module module_keypad_capture
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 27_000,
  parameter int DEBOUNCE = 270_000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [3:0]                      col_in,
  output logic [3:0]                      row_out,
  module_keypad_capture_if.master         out_if
);

  logic         key_evt;
  logic [3:0]   key_code;
  scan_state_t  scan_state;
  entry_state_t state;
  logic [3:0]   d_reg, u_reg;
  logic [3:0]   tecla_d;
  logic         load_d, load_u, rdy;
  logic [1:0]   n_digits;

  module_keypad_scan #(
    .SCAN_DIV (SCAN_DIV),
    .DEBOUNCE (DEBOUNCE)
  ) u_scan (
    .clk      (clk),
    .rst      (rst),
    .col_in   (col_in),
    .row_out  (row_out),
    .key_evt  (key_evt),
    .key_code (key_code),
    .state    (scan_state)
  );

  // Each EMIT_* state is the cycle in which its own strobe is visible, so
  // the strobe is registered on the edge that enters the state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= EMPTY;
      d_reg    <= 4'h0;
      u_reg    <= 4'h0;
      tecla_d  <= 4'h0;
      load_d   <= 1'b0;
      load_u   <= 1'b0;
      rdy      <= 1'b0;
      n_digits <= 2'd0;
    end else begin
      load_d <= 1'b0;
      load_u <= 1'b0;
      rdy    <= 1'b0;
      case (state)
        EMPTY, ONE, TWO: begin
          if (key_evt) begin
            if (key_code == KEY_STAR) begin
              d_reg    <= 4'h0;
              u_reg    <= 4'h0;
              n_digits <= 2'd0;
              state    <= EMPTY;
            end else if (key_code == KEY_HASH) begin
              if (state != EMPTY) begin
                load_d   <= 1'b1;
                tecla_d  <= d_reg;
                n_digits <= 2'd2;
                state    <= EMIT_D;
              end
            end else if (key_code <= 4'd9) begin
              if (state == EMPTY) begin
                u_reg    <= key_code;
                d_reg    <= 4'h0;
                n_digits <= 2'd1;
                state    <= ONE;
              end else if (state == ONE) begin
                // Calculator-style shift-in: previous units becomes tens.
                d_reg    <= u_reg;
                u_reg    <= key_code;
                n_digits <= 2'd2;
                state    <= TWO;
              end
            end
          end
        end
        EMIT_D: begin
          load_u  <= 1'b1;
          tecla_d <= u_reg;
          state   <= EMIT_U;
        end
        EMIT_U: begin
          rdy   <= 1'b1;
          state <= EMIT_RDY;
        end
        EMIT_RDY: begin
          d_reg    <= 4'h0;
          u_reg    <= 4'h0;
          n_digits <= 2'd0;
          state    <= EMPTY;
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign out_if.tecla_d     = tecla_d;
  assign out_if.load_d      = load_d;
  assign out_if.load_u      = load_u;
  assign out_if.rdy         = rdy;
  assign out_if.n_digits    = n_digits;
  assign out_if.scan_state  = scan_state;
  assign out_if.entry_state = state;

endmodule
